// File: rtl/synaptic_accumulator_if.sv
// Bus bundle for synaptic_accumulator: spike handshake, weight writes, bias/tick and the published current.
// master = upstream/neuron side driving the block, slave = the accumulator itself.
interface synaptic_accumulator_if #(
  parameter int SYN_ID_W = 4
);
  logic                SPIKE_VALID;
  logic                SPIKE_READY;
  logic [SYN_ID_W-1:0] SPIKE_SYN_ID;
  logic                WEIGHT_WE;
  logic [SYN_ID_W-1:0] WEIGHT_ADDR;
  logic [31:0]         WEIGHT_DATA;
  logic [31:0]         BIAS;
  logic                TICK;
  logic [31:0]         I_OUT;
  logic                I_VALID;
  logic                TICK_OVERRUN;

  modport master (
    output SPIKE_VALID, SPIKE_SYN_ID, WEIGHT_WE, WEIGHT_ADDR, WEIGHT_DATA, BIAS, TICK,
    input  SPIKE_READY, I_OUT, I_VALID, TICK_OVERRUN
  );

  modport slave (
    input  SPIKE_VALID, SPIKE_SYN_ID, WEIGHT_WE, WEIGHT_ADDR, WEIGHT_DATA, BIAS, TICK,
    output SPIKE_READY, I_OUT, I_VALID, TICK_OVERRUN
  );
endinterface

// File: rtl/synaptic_accumulator.sv
// Per-timestep synaptic current accumulator for one Izhikevich neuron (Q16.16, saturating).
// Optional feature: define SYN_DECAY_EN to carry acc >>> DECAY_SHIFT into the next timestep instead of clearing.
module synaptic_accumulator #(
  parameter int NUM_SYN     = 16,
  parameter int SYN_ID_W    = 4,
  parameter int DECAY_SHIFT = 1
) (
  input logic                  CLK,
  input logic                  RESET,
  synaptic_accumulator_if.slave bus
);

  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] DRAIN1  = 2'd1;
  localparam logic [1:0] DRAIN2  = 2'd2;
  localparam logic [1:0] PUBLISH = 2'd3;

  if (DECAY_SHIFT < 0 || DECAY_SHIFT > 31) begin : g_bad_shift
    $error("synaptic_accumulator: DECAY_SHIFT must be 0..31");
  end
  if (NUM_SYN < 1 || NUM_SYN > (1 << SYN_ID_W)) begin : g_bad_num
    $error("synaptic_accumulator: NUM_SYN does not fit SYN_ID_W");
  end

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic                spike_ready;
  logic                accept;
  logic [31:0]         weights [NUM_SYN];
  logic                s0_valid;
  logic [SYN_ID_W-1:0] s0_id;
  logic                s1_valid;
  logic [31:0]         s1_weight;
  logic [31:0]         acc;
  logic [31:0]         acc_sum;
  logic [31:0]         publish_val;
  logic [31:0]         acc_after_publish;
  logic [31:0]         i_out;
  logic                i_valid;
  logic                tick_overrun;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    if (a[31] == b[31] && s[31] != a[31])
      sat_add = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      sat_add = s;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (bus.TICK) state_next = DRAIN1;
      DRAIN1:  state_next = DRAIN2;
      DRAIN2:  state_next = PUBLISH;
      default: state_next = ACCUM;
    endcase
  end

  // The last event of a timestep lands in the accumulator on the very edge that enters
  // PUBLISH, so the published value is taken from the post-add sum, not the register.
  always_comb begin
    accept      = bus.SPIKE_VALID && spike_ready;
    acc_sum     = s1_valid ? sat_add(acc, s1_weight) : acc;
    publish_val = sat_add(acc_sum, bus.BIAS);
`ifdef SYN_DECAY_EN
    acc_after_publish = 32'($signed(acc_sum) >>> DECAY_SHIFT);
`else
    acc_after_publish = 32'd0;
`endif
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_SYN; i++) weights[i] <= 32'd0;
    end else if (bus.WEIGHT_WE && (32'(bus.WEIGHT_ADDR) < 32'(NUM_SYN))) begin
      weights[bus.WEIGHT_ADDR] <= bus.WEIGHT_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= ACCUM;
      spike_ready  <= 1'b0;
      s0_valid     <= 1'b0;
      s0_id        <= '0;
      s1_valid     <= 1'b0;
      s1_weight    <= 32'd0;
      acc          <= 32'd0;
      i_out        <= 32'd0;
      i_valid      <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      state       <= state_next;
      spike_ready <= (state_next == ACCUM);
      s0_valid    <= accept;
      if (accept) s0_id <= bus.SPIKE_SYN_ID;
      s1_valid <= s0_valid;
      // Out-of-range synapse ids still flow through the pipeline but add nothing.
      if (s0_valid)
        s1_weight <= (32'(s0_id) < 32'(NUM_SYN)) ? weights[s0_id] : 32'd0;
      i_valid <= (state_next == PUBLISH);
      if (state_next == PUBLISH) begin
        i_out <= publish_val;
        acc   <= acc_after_publish;
      end else begin
        acc <= acc_sum;
      end
      if (bus.TICK && state != ACCUM) tick_overrun <= 1'b1;
    end
  end

  assign bus.SPIKE_READY  = spike_ready;
  assign bus.I_OUT        = i_out;
  assign bus.I_VALID      = i_valid;
  assign bus.TICK_OVERRUN = tick_overrun;

endmodule
